// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// ID-stage load-use hazard detector with multi-cycle load-use latency,
// per-operand use qualifiers, optional x0 filtering, D-cache freeze handling
// and saturating stall/bubble performance counters.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   ex_memread_i        EX instruction is a load
//   ex_rd_i             EX destination register
//   id_rs1_i/id_rs2_i   ID source registers
//   id_use_rs1_i/_rs2_i ID instruction actually reads rs1/rs2
//   mem_stall_i         D-cache busy, whole pipeline must freeze
//   cnt_clr_i           synchronous clear of both counters
//   pc_write_o          1 = PC may advance
//   ifid_stall_o        1 = hold IF/ID
//   noop_o              1 = insert bubble into ID/EX
//   freeze_o            1 = hold every pipeline register
//   busy_o              1 = controller not in IDLE
//   stall_cnt_o         cycles with pc_write_o == 0 (saturating)
//   bubble_cnt_o        cycles with noop_o == 1 (saturating)
//
// Handshake: there is no valid/ready pair here; every control output is a
// level that applies to the current cycle and is derived only from the
// registered state and the current-cycle inputs (no output feeds back).
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int REG_AW          = 5,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int IGNORE_X0       = 1,
  parameter int CNT_W           = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic              mem_stall_i,
  input  logic              cnt_clr_i,
  output logic              pc_write_o,
  output logic              ifid_stall_o,
  output logic              noop_o,
  output logic              freeze_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUBBLE = 2'd1,
    FREEZE = 2'd2
  } state_e;

  // Bubbles still owed after the one issued in the hazard-detect cycle.
  localparam logic [3:0] BUB_INIT = 4'(LOAD_USE_CYCLES - 1);

  state_e           state_q, state_d;
  state_e           resume_q, resume_d;
  state_e           eff_state;
  logic [3:0]       bub_cnt_q, bub_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic hit;
  logic rd_is_x0;
  logic pc_write, ifid_stall, noop, freeze;

  // Hazard detect: load in EX whose destination a live ID operand reads.
  always_comb begin
    rd_is_x0 = (IGNORE_X0 != 0) && (ex_rd_i == '0);
    hit      = ex_memread_i && !rd_is_x0 &&
               ((id_use_rs1_i && (ex_rd_i == id_rs1_i)) ||
                (id_use_rs2_i && (ex_rd_i == id_rs2_i)));
  end

  // Next-state and output decode. When a freeze ends, the cycle behaves as
  // the state that was interrupted, so the decode runs on eff_state.
  always_comb begin
    eff_state  = (state_q == FREEZE && !mem_stall_i) ? resume_q : state_q;
    state_d    = eff_state;
    resume_d   = resume_q;
    bub_cnt_d  = bub_cnt_q;
    pc_write   = 1'b1;
    ifid_stall = 1'b0;
    noop       = 1'b0;
    freeze     = 1'b0;

    case (eff_state)
      FREEZE: begin
        freeze     = 1'b1;
        pc_write   = 1'b0;
        ifid_stall = 1'b1;
      end
      BUBBLE: begin
        if (mem_stall_i) begin
          // Bubble count is held so the total per hazard stays exact.
          freeze     = 1'b1;
          pc_write   = 1'b0;
          ifid_stall = 1'b1;
          state_d    = FREEZE;
          resume_d   = BUBBLE;
        end else begin
          pc_write   = 1'b0;
          ifid_stall = 1'b1;
          noop       = 1'b1;
          bub_cnt_d  = bub_cnt_q - 4'd1;
          state_d    = (bub_cnt_q == 4'd1) ? IDLE : BUBBLE;
        end
      end
      default: begin
        if (mem_stall_i) begin
          // Freeze wins; a hazard present now is re-evaluated on release.
          freeze     = 1'b1;
          pc_write   = 1'b0;
          ifid_stall = 1'b1;
          state_d    = FREEZE;
          resume_d   = IDLE;
        end else if (hit) begin
          pc_write   = 1'b0;
          ifid_stall = 1'b1;
          noop       = 1'b1;
          if (LOAD_USE_CYCLES > 1) begin
            state_d   = BUBBLE;
            bub_cnt_d = BUB_INIT;
          end else begin
            state_d   = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    if (rst_i) begin
      pc_write   = 1'b1;
      ifid_stall = 1'b0;
      noop       = 1'b0;
      freeze     = 1'b0;
    end
  end

  // Saturating performance counters; clear overrides increment.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr_i) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (!pc_write && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (noop && (bubble_cnt_q != '1)) begin
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      resume_q     <= IDLE;
      bub_cnt_q    <= 4'd0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      resume_q     <= resume_d;
      bub_cnt_q    <= bub_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign pc_write_o   = pc_write;
  assign ifid_stall_o = ifid_stall;
  assign noop_o       = noop;
  assign freeze_o     = freeze;
  assign busy_o       = (state_q != IDLE) && !rst_i;
  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Three instances share one stimulus stream:
//   0: LOAD_USE_CYCLES=3, IGNORE_X0=1, CNT_W=4
//   1: LOAD_USE_CYCLES=1, IGNORE_X0=0, CNT_W=16
//   2: LOAD_USE_CYCLES=1, IGNORE_X0=1, CNT_W=16
// The reference model tracks only "bubbles still owed" per instance: a
// freeze cycle issues nothing, otherwise an owed bubble is issued, otherwise
// a fresh hazard issues one and owes LOAD_USE_CYCLES-1 more.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  localparam int N = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i        = 1'b1;
  logic       ex_memread_i = 1'b0;
  logic [4:0] ex_rd_i      = '0;
  logic [4:0] id_rs1_i     = '0;
  logic [4:0] id_rs2_i     = '0;
  logic       id_use_rs1_i = 1'b0;
  logic       id_use_rs2_i = 1'b0;
  logic       mem_stall_i  = 1'b0;
  logic       cnt_clr_i    = 1'b0;

  logic        pcw  [N];
  logic        ifs  [N];
  logic        nop  [N];
  logic        frz  [N];
  logic        bsy  [N];
  logic [15:0] scnt [N];
  logic [15:0] bcnt [N];

  logic [3:0]  a_scnt, a_bcnt;
  logic [15:0] b_scnt, b_bcnt, c_scnt, c_bcnt;

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_USE_CYCLES(3), .IGNORE_X0(1), .CNT_W(4)) u_a (
    .clk_i(clk), .rst_i(rst_i), .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_use_rs1_i(id_use_rs1_i),
    .id_use_rs2_i(id_use_rs2_i), .mem_stall_i(mem_stall_i), .cnt_clr_i(cnt_clr_i),
    .pc_write_o(pcw[0]), .ifid_stall_o(ifs[0]), .noop_o(nop[0]), .freeze_o(frz[0]),
    .busy_o(bsy[0]), .stall_cnt_o(a_scnt), .bubble_cnt_o(a_bcnt));

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_USE_CYCLES(1), .IGNORE_X0(0), .CNT_W(16)) u_b (
    .clk_i(clk), .rst_i(rst_i), .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_use_rs1_i(id_use_rs1_i),
    .id_use_rs2_i(id_use_rs2_i), .mem_stall_i(mem_stall_i), .cnt_clr_i(cnt_clr_i),
    .pc_write_o(pcw[1]), .ifid_stall_o(ifs[1]), .noop_o(nop[1]), .freeze_o(frz[1]),
    .busy_o(bsy[1]), .stall_cnt_o(b_scnt), .bubble_cnt_o(b_bcnt));

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_USE_CYCLES(1), .IGNORE_X0(1), .CNT_W(16)) u_c (
    .clk_i(clk), .rst_i(rst_i), .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_use_rs1_i(id_use_rs1_i),
    .id_use_rs2_i(id_use_rs2_i), .mem_stall_i(mem_stall_i), .cnt_clr_i(cnt_clr_i),
    .pc_write_o(pcw[2]), .ifid_stall_o(ifs[2]), .noop_o(nop[2]), .freeze_o(frz[2]),
    .busy_o(bsy[2]), .stall_cnt_o(c_scnt), .bubble_cnt_o(c_bcnt));

  assign scnt[0] = {12'd0, a_scnt};
  assign bcnt[0] = {12'd0, a_bcnt};
  assign scnt[1] = b_scnt;
  assign bcnt[1] = b_bcnt;
  assign scnt[2] = c_scnt;
  assign bcnt[2] = c_bcnt;

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[u%0d] @%0t: got %0h, expected %0h", name, idx, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_lat  [N] = '{3, 1, 1};
  int m_x0   [N] = '{1, 0, 1};
  int m_max  [N] = '{15, 65535, 65535};
  int m_owed [N] = '{0, 0, 0};
  int m_busy [N] = '{0, 0, 0};
  int m_scnt [N] = '{0, 0, 0};
  int m_bcnt [N] = '{0, 0, 0};

  function automatic bit model_hit(input int i);
    if (!ex_memread_i) return 0;
    if (m_x0[i] != 0 && ex_rd_i == 0) return 0;
    return (id_use_rs1_i && ex_rd_i == id_rs1_i) || (id_use_rs2_i && ex_rd_i == id_rs2_i);
  endfunction

  // Compare on every negedge (inputs stable since posedge+1), then advance
  // the model with the same inputs the DUT samples at the next posedge.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic e_pc, e_is, e_no, e_fr, e_bs;
      bit   h;
      h    = model_hit(i);
      e_pc = 1'b1; e_is = 1'b0; e_no = 1'b0; e_fr = 1'b0; e_bs = 1'b0;
      if (!rst_i) begin
        e_bs = (m_busy[i] != 0);
        if (mem_stall_i) begin
          e_fr = 1'b1; e_pc = 1'b0; e_is = 1'b1;
        end else if (m_owed[i] > 0 || h) begin
          e_pc = 1'b0; e_is = 1'b1; e_no = 1'b1;
        end
      end
      chk("pc_write",   i, {15'd0, pcw[i]}, {15'd0, e_pc});
      chk("ifid_stall", i, {15'd0, ifs[i]}, {15'd0, e_is});
      chk("noop",       i, {15'd0, nop[i]}, {15'd0, e_no});
      chk("freeze",     i, {15'd0, frz[i]}, {15'd0, e_fr});
      chk("busy",       i, {15'd0, bsy[i]}, {15'd0, e_bs});
      chk("stall_cnt",  i, scnt[i], 16'(m_scnt[i]));
      chk("bubble_cnt", i, bcnt[i], 16'(m_bcnt[i]));

      if (rst_i) begin
        m_owed[i] = 0; m_busy[i] = 0; m_scnt[i] = 0; m_bcnt[i] = 0;
      end else begin
        if (!mem_stall_i) begin
          if (m_owed[i] > 0) m_owed[i]--;
          else if (h)        m_owed[i] = m_lat[i] - 1;
        end
        m_busy[i] = (mem_stall_i || m_owed[i] > 0) ? 1 : 0;
        if (cnt_clr_i) begin
          m_scnt[i] = 0; m_bcnt[i] = 0;
        end else begin
          if (!e_pc && m_scnt[i] < m_max[i]) m_scnt[i]++;
          if (e_no  && m_bcnt[i] < m_max[i]) m_bcnt[i]++;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic u1, input logic u2,
                      input logic ms, input logic clr, input logic rs);
    @(posedge clk);
    #1;
    ex_memread_i = mr; ex_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2;
    id_use_rs1_i = u1; id_use_rs2_i = u2; mem_stall_i = ms;
    cnt_clr_i = clr; rst_i = rs;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    // Reset held for a few cycles.
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    chk("lit_reset_pc",   2, {15'd0, pcw[2]}, 16'd1);
    chk("lit_reset_scnt", 0, scnt[0], 16'd0);

    // Single-cycle load-use: lw x5 ; add x6,x5,x7.
    tick(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick(1, 5, 5, 7, 1, 1, 0, 0, 0);
    chk("lit_lu1_pc",   2, {15'd0, pcw[2]}, 16'd0);
    chk("lit_lu1_noop", 2, {15'd0, nop[2]}, 16'd1);
    idle(1);
    chk("lit_lu1_pc_after", 2, {15'd0, pcw[2]}, 16'd1);
    chk("lit_lu1_bcnt",     2, bcnt[2], 16'd1);
    chk("lit_lu1_scnt",     2, scnt[2], 16'd1);

    // x0 destination: filtered only where IGNORE_X0=1.
    idle(4);
    tick(1, 0, 0, 3, 1, 0, 0, 0, 0);
    chk("lit_x0_filtered", 2, {15'd0, pcw[2]}, 16'd1);
    chk("lit_x0_unfilt",   1, {15'd0, nop[1]}, 16'd1);

    // rd==rs2 but rs2 unused (I-type).
    idle(4);
    tick(1, 9, 3, 9, 1, 0, 0, 0, 0);
    chk("lit_rs2_unused", 2, {15'd0, pcw[2]}, 16'd1);

    // Three-bubble hazard with a 4-cycle freeze during the 2nd bubble.
    idle(5);
    tick(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick(1, 8, 8, 0, 1, 0, 0, 0, 0);
    chk("lit_lu3_first", 0, {15'd0, nop[0]}, 16'd1);
    tick(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("lit_lu3_frz",    0, {15'd0, frz[0]}, 16'd1);
    chk("lit_lu3_frznop", 0, {15'd0, nop[0]}, 16'd0);
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_lu3_resume", 0, {15'd0, nop[0]}, 16'd1);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_lu3_last", 0, {15'd0, nop[0]}, 16'd1);
    idle(1);
    chk("lit_lu3_done", 0, {15'd0, nop[0]}, 16'd0);
    chk("lit_lu3_bcnt", 0, bcnt[0], 16'd3);
    chk("lit_lu3_scnt", 0, scnt[0], 16'd7);

    // Saturation of the 4-bit stall counter, then clear.
    tick(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 21; k++) tick(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    chk("lit_sat", 0, scnt[0], 16'd15);
    tick(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    chk("lit_clr", 0, scnt[0], 16'd0);

    // Reset while in BUBBLE aborts it.
    idle(3);
    tick(1, 4, 4, 0, 1, 0, 0, 0, 0);
    idle(1);
    chk("lit_rst_busy_pre", 0, {15'd0, bsy[0]}, 16'd1);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("lit_rst_pc", 0, {15'd0, pcw[0]}, 16'd1);
    idle(1);
    chk("lit_rst_busy", 0, {15'd0, bsy[0]}, 16'd0);
    chk("lit_rst_scnt", 0, scnt[0], 16'd0);
    chk("lit_rst_bcnt", 0, bcnt[0], 16'd0);
    chk("lit_rst_pc2",  0, {15'd0, pcw[0]}, 16'd1);

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      logic mr, u1, u2, ms, clr, rs;
      logic [4:0] rd, r1, r2;
      mr  = ($urandom_range(0, 1) == 1);
      rd  = 5'($urandom_range(0, 3));
      r1  = 5'($urandom_range(0, 3));
      r2  = 5'($urandom_range(0, 3));
      u1  = ($urandom_range(0, 3) != 0);
      u2  = ($urandom_range(0, 1) == 1);
      ms  = ($urandom_range(0, 5) == 0);
      clr = ($urandom_range(0, 49) == 0);
      rs  = ($urandom_range(0, 199) == 0);
      tick(mr, rd, r1, r2, u1, u2, ms, clr, rs);
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
